// File: rtl/axis_number_checker_if.sv
// AXI-Stream handshake bundle for the number-checker sink.
// The master modport drives the beat; the slave modport returns tready.
interface axis_number_checker_if #(
  parameter int unsigned DATA_WIDTH = 32
) ();
  logic                  tvalid;
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tlast;
  logic                  tready;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/axis_number_checker.sv
// AXI-Stream sink that checks the byte-ramp sequence and TLAST placement.
// Optional AXIS_CHECKER_BACKPRESSURE_EN gates tready with a 16-bit LFSR.
module axis_number_checker #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter logic [7:0]  START_VALUE = 8'h80
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  i_enable,
  input  logic [31:0]           i_n_value,
  axis_number_checker_if.slave  s_axis,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_pass,
  output logic                  o_err_data,
  output logic                  o_err_last,
  output logic [31:0]           o_beat_count,
  output logic [15:0]           o_err_count
);

  localparam int unsigned NUM_LANES = DATA_WIDTH / 8;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_e;

  state_e      state_q,      state_d;
  logic [31:0] n_q,          n_d;
  logic [7:0]  exp_start_q,  exp_start_d;
  logic [31:0] beat_count_q, beat_count_d;
  logic [15:0] err_count_q,  err_count_d;
  logic        err_data_q,   err_data_d;
  logic        err_last_q,   err_last_d;
  logic        pass_q,       pass_d;
  logic        done_q,       done_d;

  logic        run;
  logic        tready;
  logic        accept;
  logic        lane_mismatch;
  logic        final_beat;
  logic [31:0] beat_next;

  assign run = (state_q == ST_RUN);

`ifdef AXIS_CHECKER_BACKPRESSURE_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Right-shifting Fibonacci form of taps 16,14,13,11
  always_comb begin
    lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign tready = run & lfsr_q[0];
`else
  assign tready = run;
`endif

  assign s_axis.tready = tready;
  assign accept        = s_axis.tvalid & tready;
  assign beat_next     = beat_count_q + 32'd1;
  assign final_beat    = (beat_next == n_q);

  always_comb begin
    lane_mismatch = 1'b0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      if (s_axis.tdata[i*8 +: 8] != exp_start_q + 8'(i)) begin
        lane_mismatch = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    exp_start_d  = exp_start_q;
    beat_count_d = beat_count_q;
    err_count_d  = err_count_q;
    err_data_d   = err_data_q;
    err_last_d   = err_last_q;
    pass_d       = pass_q;
    done_d       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (i_enable && (i_n_value != '0)) begin
          state_d      = ST_RUN;
          n_d          = i_n_value;
          exp_start_d  = START_VALUE;
          beat_count_d = '0;
          err_count_d  = '0;
          err_data_d   = 1'b0;
          err_last_d   = 1'b0;
          pass_d       = 1'b0;
        end
      end
      ST_RUN: begin
        if (accept) begin
          beat_count_d = beat_next;
          exp_start_d  = exp_start_q + 8'(NUM_LANES);
          if (lane_mismatch) begin
            err_data_d = 1'b1;
            if (err_count_q != '1) begin
              err_count_d = err_count_q + 16'd1;
            end
          end
          if (s_axis.tlast != final_beat) begin
            err_last_d = 1'b1;
          end
          // Early TLAST and missing TLAST both close the sequence on this beat
          if (s_axis.tlast || final_beat) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            pass_d  = !(err_data_d || err_last_d);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= ST_IDLE;
      n_q          <= '0;
      exp_start_q  <= START_VALUE;
      beat_count_q <= '0;
      err_count_q  <= '0;
      err_data_q   <= 1'b0;
      err_last_q   <= 1'b0;
      pass_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      exp_start_q  <= exp_start_d;
      beat_count_q <= beat_count_d;
      err_count_q  <= err_count_d;
      err_data_q   <= err_data_d;
      err_last_q   <= err_last_d;
      pass_q       <= pass_d;
      done_q       <= done_d;
    end
  end

  assign o_busy       = run;
  assign o_done       = done_q;
  assign o_pass       = pass_q;
  assign o_err_data   = err_data_q;
  assign o_err_last   = err_last_q;
  assign o_beat_count = beat_count_q;
  assign o_err_count  = err_count_q;

endmodule
